mac_pipelined: RTL and testbench

Parametrised, three-stage pipelined multiply-accumulate unit; the next-generation replacement for the single-cycle 32-bit `mac`. It adds a valid/first/last framing protocol, signed or unsigned operands selected per beat, and saturating accumulation with a sticky overflow flag. It also keeps a term counter. It sits between the operand sequencer and the result writeback, one beat per clock, with no backpressure.

---
 rtl/mac_pkg.sv | 33 +++
 rtl/mac_mult_stage.sv | 75 +++++++
 rtl/mac_pipelined.sv | 126 ++++++++++++
 tb/tb_mac_pipelined.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types, default widths and saturation-limit helpers for the pipelined MAC.
package mac_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ACC_W  = 72;
  localparam int unsigned DEF_CNT_W  = 16;
  localparam int unsigned DEF_PROD_W = 2 * DEF_DATA_W;

  // Widest accumulator the limit helpers can describe.
  localparam int unsigned MAX_W = 256;

  typedef logic [MAX_W-1:0] wide_t;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
    logic signed_mode;
  } beat_flags_t;

  function automatic wide_t sat_max_unsigned(input int unsigned w);
    return {MAX_W{1'b1}} >> (MAX_W - w);
  endfunction

  function automatic wide_t sat_max_signed(input int unsigned w);
    return {MAX_W{1'b1}} >> (MAX_W - w + 1);
  endfunction

  function automatic wide_t sat_min_signed(input int unsigned w);
    return {{(MAX_W-1){1'b0}}, 1'b1} << (w - 1);
  endfunction

endpackage

// File: rtl/mac_mult_stage.sv
// Operand register (S1) and product register (S2) of the MAC; one multiplier
// serves both modes by sign- or zero-extending the operands to the product width.
module mac_mult_stage
  import mac_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic                  in_first,
  input  logic                  in_last,
  input  logic                  signed_mode,
  input  logic [DATA_W-1:0]     multiplicand,
  input  logic [DATA_W-1:0]     multiplier,
  output logic [2*DATA_W-1:0]   prod,
  output logic                  prod_valid,
  output logic                  prod_first,
  output logic                  prod_last,
  output logic                  prod_signed
);

  localparam int unsigned PROD_W = 2 * DATA_W;

  beat_flags_t       s1_flags_d, s1_flags_q;
  beat_flags_t       s2_flags_d, s2_flags_q;
  logic [DATA_W-1:0] a_d, a_q;
  logic [DATA_W-1:0] b_d, b_q;
  logic [PROD_W-1:0] a_ext, b_ext;
  logic [PROD_W-1:0] prod_d, prod_q;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned; a missed branch would otherwise infer a latch.
  always_comb begin
    s1_flags_d = '{valid:       in_valid,
                   first:       in_valid & in_first,
                   last:        in_valid & in_last,
                   signed_mode: signed_mode};
    a_d = multiplicand;
    b_d = multiplier;

    // The low PROD_W bits of the extended product are exact in both modes.
    a_ext = s1_flags_q.signed_mode ? {{DATA_W{a_q[DATA_W-1]}}, a_q} : {{DATA_W{1'b0}}, a_q};
    b_ext = s1_flags_q.signed_mode ? {{DATA_W{b_q[DATA_W-1]}}, b_q} : {{DATA_W{1'b0}}, b_q};
    prod_d     = a_ext * b_ext;
    s2_flags_d = s1_flags_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_flags_q <= '0;
      s2_flags_q <= '0;
    end else begin
      s1_flags_q <= s1_flags_d;
      s2_flags_q <= s2_flags_d;
    end
  end

  // NOTE: datapath registers carry no reset; the valid bits alone decide
  // whether their contents are ever consumed.
  always_ff @(posedge clk) begin
    a_q    <= a_d;
    b_q    <= b_d;
    prod_q <= prod_d;
  end

  assign prod        = prod_q;
  assign prod_valid  = s2_flags_q.valid;
  assign prod_first  = s2_flags_q.first;
  assign prod_last   = s2_flags_q.last;
  assign prod_signed = s2_flags_q.signed_mode;

endmodule

// File: rtl/mac_pipelined.sv
// Three-stage pipelined multiply-accumulate with first/last framing, per-beat
// signed/unsigned operands, saturating or wrapping accumulation and a term counter.
module mac_pipelined
  import mac_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ACC_W    = DEF_ACC_W,
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter bit          SATURATE = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_first,
  input  logic              in_last,
  input  logic              signed_mode,
  input  logic [DATA_W-1:0] multiplicand,
  input  logic [DATA_W-1:0] multiplier,
  output logic [ACC_W-1:0]  accumulator_out,
  output logic              acc_valid,
  output logic              overflow,
  output logic [CNT_W-1:0]  term_count
);

  localparam int unsigned PROD_W = 2 * DATA_W;

  if (ACC_W < PROD_W) begin : g_acc_too_narrow
    $error("mac_pipelined: ACC_W (%0d) must be at least 2*DATA_W (%0d)", ACC_W, PROD_W);
  end
  if (ACC_W > MAX_W) begin : g_acc_too_wide
    $error("mac_pipelined: ACC_W (%0d) exceeds MAX_W (%0d)", ACC_W, MAX_W);
  end

  localparam wide_t            SMAX_WIDE = sat_max_signed(ACC_W);
  localparam wide_t            SMIN_WIDE = sat_min_signed(ACC_W);
  localparam wide_t            UMAX_WIDE = sat_max_unsigned(ACC_W);
  localparam logic [ACC_W-1:0] SMAX      = SMAX_WIDE[ACC_W-1:0];
  localparam logic [ACC_W-1:0] SMIN      = SMIN_WIDE[ACC_W-1:0];
  localparam logic [ACC_W-1:0] UMAX      = UMAX_WIDE[ACC_W-1:0];

  logic [PROD_W-1:0] s2_prod;
  beat_flags_t       s2;

  mac_mult_stage #(
    .DATA_W (DATA_W)
  ) u_mult (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_first     (in_first),
    .in_last      (in_last),
    .signed_mode  (signed_mode),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .prod         (s2_prod),
    .prod_valid   (s2.valid),
    .prod_first   (s2.first),
    .prod_last    (s2.last),
    .prod_signed  (s2.signed_mode)
  );

  logic [ACC_W-1:0] acc_d, acc_q;
  logic             ovf_d, ovf_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             acc_valid_d, acc_valid_q;

  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W:0]   sum_full;
  logic [ACC_W-1:0] sum;
  logic             add_ovf;
  logic [ACC_W-1:0] clamp;

  always_comb begin
    prod_ext = s2.signed_mode ? ACC_W'($signed(s2_prod)) : ACC_W'(s2_prod);
    sum_full = {1'b0, acc_q} + {1'b0, prod_ext};
    sum      = sum_full[ACC_W-1:0];

    // Signed overflow: addends agree in sign but the sum does not.
    if (s2.signed_mode) begin
      add_ovf = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);
      clamp   = prod_ext[ACC_W-1] ? SMIN : SMAX;
    end else begin
      add_ovf = sum_full[ACC_W];
      clamp   = UMAX;
    end

    acc_d       = acc_q;
    ovf_d       = ovf_q;
    cnt_d       = cnt_q;
    acc_valid_d = 1'b0;

    if (s2.valid) begin
      acc_valid_d = s2.last;
      if (s2.first) begin
        // A lone product always fits because ACC_W >= 2*DATA_W.
        acc_d = prod_ext;
        ovf_d = 1'b0;
        cnt_d = CNT_W'(1);
      end else begin
        acc_d = (add_ovf && SATURATE) ? clamp : sum;
        ovf_d = ovf_q | add_ovf;
        cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      acc_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      acc_valid_q <= acc_valid_d;
    end
  end

  assign accumulator_out = acc_q;
  assign acc_valid       = acc_valid_q;
  assign overflow        = ovf_q;
  assign term_count      = cnt_q;

endmodule

// File: tb/tb_mac_pipelined.sv
// Scoreboard bench for mac_pipelined: one default-width instance plus two
// 8x8->16 instances (saturating and wrapping) fed the same small-operand beats.
module tb_mac_pipelined;

  typedef struct {
    logic [71:0] acc;
    logic        ovf;
    logic [15:0] cnt;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Default-width instance
  logic        w_valid, w_first, w_last, w_sm;
  logic [31:0] w_a, w_b;
  logic [71:0] w_acc;
  logic        w_av, w_ovf;
  logic [15:0] w_cnt;

  // Shared stimulus for the two narrow instances
  logic        s_valid, s_first, s_last, s_sm;
  logic [7:0]  s_a, s_b;
  logic [15:0] s_acc, x_acc;
  logic        s_av, s_ovf, x_av, x_ovf;
  logic [15:0] s_cnt, x_cnt;

  exp_t q_w[$];
  exp_t q_s[$];
  exp_t q_x[$];

  mac_pipelined u_wide (
    .clk (clk), .reset (reset),
    .in_valid (w_valid), .in_first (w_first), .in_last (w_last), .signed_mode (w_sm),
    .multiplicand (w_a), .multiplier (w_b),
    .accumulator_out (w_acc), .acc_valid (w_av), .overflow (w_ovf), .term_count (w_cnt)
  );

  mac_pipelined #(.DATA_W(8), .ACC_W(16), .CNT_W(16), .SATURATE(1'b1)) u_sat (
    .clk (clk), .reset (reset),
    .in_valid (s_valid), .in_first (s_first), .in_last (s_last), .signed_mode (s_sm),
    .multiplicand (s_a), .multiplier (s_b),
    .accumulator_out (s_acc), .acc_valid (s_av), .overflow (s_ovf), .term_count (s_cnt)
  );

  mac_pipelined #(.DATA_W(8), .ACC_W(16), .CNT_W(16), .SATURATE(1'b0)) u_wrap (
    .clk (clk), .reset (reset),
    .in_valid (s_valid), .in_first (s_first), .in_last (s_last), .signed_mode (s_sm),
    .multiplicand (s_a), .multiplier (s_b),
    .accumulator_out (x_acc), .acc_valid (x_av), .overflow (x_ovf), .term_count (x_cnt)
  );

  task automatic check(input string nm, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic score(input string nm, input exp_t e, input logic [71:0] acc,
                       input logic ovf, input logic [15:0] cnt);
    check({nm, "_acc"}, acc, e.acc);
    check({nm, "_ovf"}, 72'(ovf), 72'(e.ovf));
    check({nm, "_cnt"}, 72'(cnt), 72'(e.cnt));
    check({nm, "_cycle"}, 72'(cyc), 72'(e.cyc));
  endtask

  // Monitor: pops one expectation per acc_valid pulse, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (w_av) begin
      if (q_w.size() == 0) check("wide_spurious_acc_valid", 72'(w_av), 72'(0));
      else begin e = q_w.pop_front(); score("wide", e, w_acc, w_ovf, w_cnt); end
    end
    if (s_av) begin
      if (q_s.size() == 0) check("sat_spurious_acc_valid", 72'(s_av), 72'(0));
      else begin e = q_s.pop_front(); score("sat", e, 72'(s_acc), s_ovf, s_cnt); end
    end
    if (x_av) begin
      if (q_x.size() == 0) check("wrap_spurious_acc_valid", 72'(x_av), 72'(0));
      else begin e = q_x.pop_front(); score("wrap", e, 72'(x_acc), x_ovf, x_cnt); end
    end
  end

  task automatic idle();
    @(negedge clk);
    w_valid = 1'b0; w_first = 1'b0; w_last = 1'b0;
    s_valid = 1'b0; s_first = 1'b0; s_last = 1'b0;
  endtask

  task automatic beat_w(input logic f, input logic l, input logic sm,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [71:0] e_acc, input logic e_ovf, input logic [15:0] e_cnt);
    @(negedge clk);
    w_valid = 1'b1; w_first = f; w_last = l; w_sm = sm; w_a = a; w_b = b;
    s_valid = 1'b0; s_first = 1'b0; s_last = 1'b0;
    if (l) q_w.push_back('{acc: e_acc, ovf: e_ovf, cnt: e_cnt, cyc: cyc + 3});
  endtask

  task automatic beat_s(input logic f, input logic l, input logic sm,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] e_sat, input logic e_sat_ovf,
                        input logic [15:0] e_wrap, input logic e_wrap_ovf,
                        input logic [15:0] e_cnt);
    @(negedge clk);
    s_valid = 1'b1; s_first = f; s_last = l; s_sm = sm; s_a = a; s_b = b;
    w_valid = 1'b0; w_first = 1'b0; w_last = 1'b0;
    if (l) begin
      q_s.push_back('{acc: 72'(e_sat),  ovf: e_sat_ovf,  cnt: e_cnt, cyc: cyc + 3});
      q_x.push_back('{acc: 72'(e_wrap), ovf: e_wrap_ovf, cnt: e_cnt, cyc: cyc + 3});
    end
  endtask

  task automatic settle();
    repeat (3) idle();
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_wide_acc"}, w_acc, 72'(0));
    check({nm, "_wide_ovf"}, 72'(w_ovf), 72'(0));
    check({nm, "_wide_cnt"}, 72'(w_cnt), 72'(0));
    check({nm, "_wide_valid"}, 72'(w_av), 72'(0));
    check({nm, "_sat_acc"}, 72'(s_acc), 72'(0));
    check({nm, "_wrap_cnt"}, 72'(x_cnt), 72'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    w_valid = 1'b0; w_first = 1'b0; w_last = 1'b0; w_sm = 1'b0; w_a = '0; w_b = '0;
    s_valid = 1'b0; s_first = 1'b0; s_last = 1'b0; s_sm = 1'b0; s_a = '0; s_b = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    idle();

    // Unsigned single-term sum
    beat_w(1, 1, 0, 32'h1111_1111, 32'h1111_1111, 72'h0123_4567_8765_4321, 0, 1);
    settle();

    // Signed three-term sum with a bubble: 1 - 6 + 25 = 20
    beat_w(1, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '0, 0, 0);
    beat_w(0, 0, 1, 32'hFFFF_FFFE, 32'd3, '0, 0, 0);
    idle();
    beat_w(0, 1, 1, 32'd5, 32'd5, 72'd20, 0, 3);
    settle();

    // Signed 127*127 x3: saturate to 32767 vs wrap to 48387 (0xBD03)
    beat_s(1, 0, 1, 8'd127, 8'd127, '0, 0, '0, 0, '0);
    settle();
    check("s127_sum1_sat", 72'(s_acc), 72'd16129);
    check("s127_sum1_wrap", 72'(x_acc), 72'd16129);
    beat_s(0, 0, 1, 8'd127, 8'd127, '0, 0, '0, 0, '0);
    settle();
    check("s127_sum2_sat", 72'(s_acc), 72'd32258);
    check("s127_sum2_ovf", 72'(s_ovf), 72'd0);
    beat_s(0, 1, 1, 8'd127, 8'd127, 16'd32767, 1, 16'd48387, 1, 16'd3);
    settle();

    // Unsigned 255*255 x2: saturate to 65535 vs wrap to 64514
    beat_s(1, 0, 0, 8'd255, 8'd255, '0, 0, '0, 0, '0);
    settle();
    check("u255_sum1_sat", 72'(s_acc), 72'd65025);
    beat_s(0, 1, 0, 8'd255, 8'd255, 16'd65535, 1, 16'd64514, 1, 16'd2);
    settle();
    check("u255_sticky_ovf", 72'(s_ovf), 72'd1);
    beat_s(1, 1, 0, 8'd1, 8'd1, 16'd1, 0, 16'd1, 0, 16'd1);
    settle();

    // Back-to-back sums: pulses on consecutive cycles, independent results
    beat_w(1, 0, 0, 32'd3, 32'd4, '0, 0, 0);
    beat_w(0, 1, 0, 32'd5, 32'd6, 72'd42, 0, 2);
    beat_w(1, 1, 0, 32'd7, 32'd8, 72'd56, 0, 1);
    beat_w(1, 0, 1, 32'hFFFF_FFFD, 32'd4, '0, 0, 0);
    beat_w(0, 1, 1, 32'd2, 32'd2, 72'hFF_FFFF_FFFF_FFFF_FFF8, 0, 2);
    settle();

    // Reset one cycle after beat 2 of a four-beat sum; beats 3 and 4 are dropped
    beat_w(1, 0, 0, 32'd1, 32'd1, '0, 0, 0);
    beat_w(0, 0, 0, 32'd2, 32'd2, '0, 0, 0);
    @(negedge clk);
    reset = 1'b1; w_valid = 1'b1; w_first = 1'b0; w_last = 1'b0; w_a = 32'd3; w_b = 32'd3;
    @(negedge clk);
    w_last = 1'b1; w_a = 32'd4; w_b = 32'd4;
    @(negedge clk);
    reset = 1'b0; w_valid = 1'b0; w_last = 1'b0;
    check_all_zero("midsum_reset");
    repeat (4) idle();
    check("post_reset_acc_held", w_acc, 72'(0));
    beat_w(1, 1, 0, 32'd2, 32'd3, 72'd6, 0, 1);
    repeat (5) idle();

    check("wide_pending", 72'(q_w.size()), 72'(0));
    check("sat_pending", 72'(q_s.size()), 72'(0));
    check("wrap_pending", 72'(q_x.size()), 72'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
